chaining_record_manager: RTL and testbench
==========================================

Name: chaining_record_manager

Overview:
- Owns a table of RECORD_NUM vector chaining records, one per in-flight writing instruction, and keeps each record's per-element written mask.
- Allocates records at issue, sets mask bits as write-back elements land, and frees records on completion or retire.
- Answers READ_PORTS concurrent RAW chaining queries from the VRF read arbiter, registered and one cycle later.
- Sits between the issue/sequencer stage, the VRF write port and the VRF read arbitration.

Parameters:
- RECORD_NUM, 4, number of chaining records.
- READ_PORTS, 2, number of independent query ports.
- ELEM_NUM, 512, mask bits per record (8 registers x 64 element slots).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  allocation request.
- alloc_ready  out  1  a FREE record exists.
- alloc_vd_valid  in  1  instruction writes a vector destination.
- alloc_vd  in  5  destination base register.
- alloc_instIndex  in  3  instruction index; bit 2 is the wrap bit.
- alloc_vl  in  10  element count, 1..512.
- write_valid  in  1  one element written this cycle.
- write_instIndex  in  3  writing instruction.
- write_vd  in  5  written register.
- write_offset  in  6  written element slot.
- retire_valid  in  1  force-free request.
- retire_instIndex  in  3  instruction to free.
- read_valid  in  READ_PORTS  query valid, one bit per port.
- read_vs  in  READ_PORTS*5  queried register, per port.
- read_offset  in  READ_PORTS*6  queried element slot, per port.
- read_instIndex  in  READ_PORTS*3  reading instruction, per port.
- resp_valid  out  READ_PORTS  response valid.
- resp_ok  out  READ_PORTS  1 = read may proceed, 0 = chaining stall.
- err_dup  out  1  sticky flag: duplicate allocation seen.

Behaviour:
- Record fields: state, vd_valid, vd, instIndex, vl, mask[511:0], cnt[9:0].
- Record states: FREE, ACTIVE, COMPLETE.
- Reset (async): all records FREE, masks 0, resp_valid=0, resp_ok=1, err_dup=0.
- alloc_ready is 1 when any record is FREE, computed from the current registered state.
- Allocation fires on alloc_valid & alloc_ready:
  - Target is the lowest-numbered FREE record.
  - Record goes to ACTIVE with mask bits [vl-1:0]=0, mask bits >= vl set to 1, and cnt=0.
  - If an active record already holds the same instIndex: nothing is installed and err_dup is set (sticky).
- Write fires on write_valid to the ACTIVE record whose instIndex matches:
  - rel = ({write_vd,write_offset} - {rec.vd,6'b0}) mod 2048.
  - If rel < 512 and mask[rel]==0: set mask[rel] and increment cnt.
  - Repeated writes to the same element do not increment cnt.
  - rel >= 512, or no matching record: write is ignored.
- When cnt reaches vl, the record moves ACTIVE->COMPLETE. The next cycle COMPLETE->FREE.
- retire_valid frees the matching record next cycle from any state.
  - If retire and write hit the same record in the same cycle, retire wins.
- Older test: older = (r.idx[1:0] < rec.idx[1:0]) ^ r.idx[2] ^ rec.idx[2]. sameInst is an exact index match.
- Per record the check matches the established chaining rule:
  - Hazard when rec.vd_valid, record is not FREE, !sameInst, !older, and the read element is inside the record's two-group window [vd, vd+16) with its shifted mask bit 0.
  - Bits outside the record's mask read as 1 (no hazard).
- resp_ok = AND over records of !hazard.
  - resp_valid = read_valid and resp_ok are registered: latency exactly 1 cycle, with no backpressure.
- Simultaneous events: a query evaluates pre-update state, so same-cycle allocs are invisible and same-cycle writes do not clear the stall. A slot freed this cycle is allocatable next cycle.
- The 3-bit instIndex wraps; at most 4 outstanding indices are legal.

Optional Feature:
- CHAINING_STATS_EN:
  - When defined, adds an output port stall_cnt (READ_PORTS*32). Per port it increments on each resp_valid & !resp_ok, saturates at 2^32-1, and resets to 0.
  - When undefined, the port and its counters do not exist; the rest of the behaviour is unchanged.

Decomposition:
- Package chaining_pkg holds:
  - rec_state_e {FREE, ACTIVE, COMPLETE};
  - chaining_record_t struct;
  - constants ELEM_NUM, OFFSET_W=6, VS_W=5, IDX_W=3;
  - function is_older(readIdx, recIdx).
- Sub-module chaining_hazard_check: combinational, one record vs one query, returning hazard. It is instantiated RECORD_NUM x READ_PORTS times.

Test Plan:
- Reset, then alloc vd=8, idx=1, vl=64; query port0 vs=8, off=5, idx=2 -> next cycle resp_valid=1, resp_ok=0.
- Same setup, write vd=8, off=5, then query vs=8, off=5 one cycle later -> resp_ok=1. Query off=6 -> resp_ok=0.
- Alloc vl=2, write off=0 and off=1 -> COMPLETE, then FREE within 2 cycles. alloc_ready stays 1 and the record index is reused by the next alloc.
- Fill 4 records -> alloc_ready=0. Retire idx=0 -> alloc_ready=1 the next cycle. Duplicate alloc idx=2 while active -> err_dup=1, record count unchanged.
- Wrap: record idx=3, query idx=4 (wrap bit set) -> treated as younger, stalls. Record idx=4, query idx=3 -> older, resp_ok=1.
- Two ports query in the same cycle as a write to the queried element -> both return resp_ok=0 (pre-update state). With CHAINING_STATS_EN, stall_cnt for both ports increments by 1.

Source files
------------

// File: rtl/chaining_record_manager_pkg.sv
// chaining_pkg: shared widths, record type and helpers for the vector chaining record manager.
package chaining_pkg;

  localparam int ELEM_NUM = 512;
  localparam int OFFSET_W = 6;
  localparam int VS_W     = 5;
  localparam int IDX_W    = 3;
  localparam int VL_W     = 10;
  localparam int ADDR_W   = VS_W + OFFSET_W;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2
  } rec_state_e;

  typedef struct packed {
    rec_state_e          state;
    logic                vdValid;
    logic [VS_W-1:0]     vd;
    logic [IDX_W-1:0]    instIndex;
    logic [VL_W-1:0]     vl;
    logic [ELEM_NUM-1:0] mask;
    logic [VL_W-1:0]     cnt;
  } chaining_record_t;

  localparam chaining_record_t REC_RESET = '{
    state:     FREE,
    vdValid:   1'b0,
    vd:        5'd0,
    instIndex: 3'd0,
    vl:        10'd0,
    mask:      {ELEM_NUM{1'b0}},
    cnt:       10'd0
  };

  // The wrap bit flips the sense of the low-bit age comparison.
  function automatic logic is_older(input logic [IDX_W-1:0] readIdx,
                                    input logic [IDX_W-1:0] recIdx);
    return (readIdx[1:0] < recIdx[1:0]) ^ readIdx[2] ^ recIdx[2];
  endfunction

  // Element distance from a record's base register, modulo the 2048-element VRF.
  function automatic logic [ADDR_W-1:0] rel_elem(input logic [VS_W-1:0]     vs,
                                                 input logic [OFFSET_W-1:0] offset,
                                                 input logic [VS_W-1:0]     vd);
    return {vs, offset} - {vd, 6'd0};
  endfunction

  // Elements at or beyond vl are never written, so they start out marked.
  function automatic logic [ELEM_NUM-1:0] init_mask(input logic [VL_W-1:0] vl);
    logic [ELEM_NUM-1:0] one;
    one = {{(ELEM_NUM-1){1'b0}}, 1'b1};
    return ~((one << vl) - one);
  endfunction

endpackage

// File: rtl/chaining_record_manager_if.sv
// chaining_record_manager_if: issue, write-back, retire and RAW query bundle of the chaining manager.
interface chaining_record_manager_if #(
  parameter int READ_PORTS = 2
);
  import chaining_pkg::*;

  logic                           alloc_valid;
  logic                           alloc_ready;
  logic                           alloc_vd_valid;
  logic [VS_W-1:0]                alloc_vd;
  logic [IDX_W-1:0]               alloc_instIndex;
  logic [VL_W-1:0]                alloc_vl;
  logic                           write_valid;
  logic [IDX_W-1:0]               write_instIndex;
  logic [VS_W-1:0]                write_vd;
  logic [OFFSET_W-1:0]            write_offset;
  logic                           retire_valid;
  logic [IDX_W-1:0]               retire_instIndex;
  logic [READ_PORTS-1:0]          read_valid;
  logic [READ_PORTS*VS_W-1:0]     read_vs;
  logic [READ_PORTS*OFFSET_W-1:0] read_offset;
  logic [READ_PORTS*IDX_W-1:0]    read_instIndex;
  logic [READ_PORTS-1:0]          resp_valid;
  logic [READ_PORTS-1:0]          resp_ok;
  logic                           err_dup;

  modport master (
    output alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex, alloc_vl,
    output write_valid, write_instIndex, write_vd, write_offset,
    output retire_valid, retire_instIndex,
    output read_valid, read_vs, read_offset, read_instIndex,
    input  alloc_ready, resp_valid, resp_ok, err_dup
  );

  modport slave (
    input  alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex, alloc_vl,
    input  write_valid, write_instIndex, write_vd, write_offset,
    input  retire_valid, retire_instIndex,
    input  read_valid, read_vs, read_offset, read_instIndex,
    output alloc_ready, resp_valid, resp_ok, err_dup
  );

endinterface

// File: rtl/chaining_record_manager_hazard_check.sv
// chaining_hazard_check: combinational RAW chaining check of one query against one record.
module chaining_hazard_check
  import chaining_pkg::*;
(
  input  rec_state_e          recState,
  input  logic                recVdValid,
  input  logic [VS_W-1:0]     recVd,
  input  logic [IDX_W-1:0]    recInstIndex,
  input  logic [ELEM_NUM-1:0] recMask,
  input  logic [VS_W-1:0]     readVs,
  input  logic [OFFSET_W-1:0] readOffset,
  input  logic [IDX_W-1:0]    readInstIndex,
  output logic                hazard
);

  logic [ADDR_W-1:0] rel_s;
  logic              inWindow_s;
  logic              maskBit_s;
  logic              sameInst_s;
  logic              older_s;

  // Stall only for a younger reader touching an unwritten element of the two-group window.
  always_comb begin
    rel_s      = rel_elem(readVs, readOffset, recVd);
    inWindow_s = (rel_s < 11'd1024);
    if (rel_s < 11'd512) begin
      maskBit_s = recMask[rel_s[8:0]];
    end else begin
      maskBit_s = 1'b1;
    end
    sameInst_s = (readInstIndex == recInstIndex);
    older_s    = is_older(readInstIndex, recInstIndex);
    hazard     = recVdValid && (recState != FREE) && !sameInst_s && !older_s &&
                 inWindow_s && !maskBit_s;
  end

endmodule

// File: rtl/chaining_record_manager.sv
// chaining_record_manager: vector chaining record table with registered RAW query ports.
// Optional CHAINING_STATS_EN adds per-port saturating stall counters on stall_cnt.
module chaining_record_manager
  import chaining_pkg::*;
#(
  parameter int RECORD_NUM = 4,
  parameter int READ_PORTS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  chaining_record_manager_if.slave bus
`ifdef CHAINING_STATS_EN
  ,
  output logic [READ_PORTS*32-1:0] stall_cnt
`endif
);

  localparam int SEL_W = (RECORD_NUM > 1) ? $clog2(RECORD_NUM) : 1;

  chaining_record_t                 rec_r   [RECORD_NUM];
  chaining_record_t                 rec_s   [RECORD_NUM];
  logic [ADDR_W-1:0]                wrRel_s [RECORD_NUM];
  logic                             anyFree_s;
  logic                             dupHit_s;
  logic                             allocFire_s;
  logic [SEL_W-1:0]                 allocSel_s;
  logic [READ_PORTS*RECORD_NUM-1:0] hazard_s;
  logic [READ_PORTS-1:0]            okAll_s;
  logic [READ_PORTS-1:0]            respValid_r;
  logic [READ_PORTS-1:0]            respOk_r;
  logic                             errDup_r;

  // Lowest free slot and duplicate-index detection from the registered table.
  always_comb begin
    anyFree_s  = 1'b0;
    dupHit_s   = 1'b0;
    allocSel_s = {SEL_W{1'b0}};
    for (int i = RECORD_NUM - 1; i >= 0; i--) begin
      if (rec_r[i].state == FREE) begin
        anyFree_s  = 1'b1;
        allocSel_s = SEL_W'(i);
      end else begin
        dupHit_s = dupHit_s | (rec_r[i].instIndex == bus.alloc_instIndex);
      end
    end
    allocFire_s = bus.alloc_valid & anyFree_s;
  end

  // Per-record state machine: install, element write-back, completion and release.
  always_comb begin
    for (int i = 0; i < RECORD_NUM; i++) begin
      rec_s[i]   = rec_r[i];
      wrRel_s[i] = rel_elem(bus.write_vd, bus.write_offset, rec_r[i].vd);
      case (rec_r[i].state)
        FREE: begin
          if (allocFire_s && !dupHit_s && (allocSel_s == SEL_W'(i))) begin
            rec_s[i].state     = ACTIVE;
            rec_s[i].vdValid   = bus.alloc_vd_valid;
            rec_s[i].vd        = bus.alloc_vd;
            rec_s[i].instIndex = bus.alloc_instIndex;
            rec_s[i].vl        = bus.alloc_vl;
            rec_s[i].mask      = init_mask(bus.alloc_vl);
            rec_s[i].cnt       = 10'd0;
          end else begin
            rec_s[i].state = FREE;
          end
        end
        ACTIVE: begin
          // Retire takes priority over a same-cycle write to the same record.
          if (bus.retire_valid && (rec_r[i].instIndex == bus.retire_instIndex)) begin
            rec_s[i].state = FREE;
          end else if (bus.write_valid && (rec_r[i].instIndex == bus.write_instIndex) &&
                       (wrRel_s[i] < 11'd512) && !rec_r[i].mask[wrRel_s[i][8:0]]) begin
            rec_s[i].mask[wrRel_s[i][8:0]] = 1'b1;
            rec_s[i].cnt                   = rec_r[i].cnt + 10'd1;
            if ((rec_r[i].cnt + 10'd1) == rec_r[i].vl) begin
              rec_s[i].state = COMPLETE;
            end else begin
              rec_s[i].state = ACTIVE;
            end
          end else begin
            rec_s[i].state = ACTIVE;
          end
        end
        COMPLETE: begin
          rec_s[i].state = FREE;
        end
        default: begin
          rec_s[i].state = FREE;
        end
      endcase
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    for (genvar r = 0; r < RECORD_NUM; r++) begin : g_rec
      chaining_hazard_check u_check (
        .recState      (rec_r[r].state),
        .recVdValid    (rec_r[r].vdValid),
        .recVd         (rec_r[r].vd),
        .recInstIndex  (rec_r[r].instIndex),
        .recMask       (rec_r[r].mask),
        .readVs        (bus.read_vs[p*VS_W +: VS_W]),
        .readOffset    (bus.read_offset[p*OFFSET_W +: OFFSET_W]),
        .readInstIndex (bus.read_instIndex[p*IDX_W +: IDX_W]),
        .hazard        (hazard_s[p*RECORD_NUM + r])
      );
    end
    assign okAll_s[p] = ~|hazard_s[p*RECORD_NUM +: RECORD_NUM];
  end

  // Record table, one-cycle query responses and the sticky duplicate flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RECORD_NUM; i++) begin
        rec_r[i] <= REC_RESET;
      end
      respValid_r <= {READ_PORTS{1'b0}};
      respOk_r    <= {READ_PORTS{1'b1}};
      errDup_r    <= 1'b0;
    end else begin
      for (int i = 0; i < RECORD_NUM; i++) begin
        rec_r[i] <= rec_s[i];
      end
      respValid_r <= bus.read_valid;
      respOk_r    <= ~bus.read_valid | okAll_s;
      errDup_r    <= errDup_r | (allocFire_s & dupHit_s);
    end
  end

  assign bus.alloc_ready = anyFree_s;
  assign bus.resp_valid  = respValid_r;
  assign bus.resp_ok     = respOk_r;
  assign bus.err_dup     = errDup_r;

`ifdef CHAINING_STATS_EN
  logic [READ_PORTS*32-1:0] stallCnt_r;

  // Saturating per-port count of stalled responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCnt_r <= {(READ_PORTS*32){1'b0}};
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if (respValid_r[p] && !respOk_r[p] && (stallCnt_r[p*32 +: 32] != 32'hFFFF_FFFF)) begin
          stallCnt_r[p*32 +: 32] <= stallCnt_r[p*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt = stallCnt_r;
`endif

endmodule

// File: tb/tb_chaining_record_manager.sv
// Self-checking bench for chaining_record_manager: directed cases plus randomized traffic
// compared against a record-set reference model (stall counters when CHAINING_STATS_EN is set).
module tb_chaining_record_manager;
  import chaining_pkg::*;

  localparam int RN = 4;
  localparam int RP = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  chaining_record_manager_if #(.READ_PORTS(RP)) bus ();
`ifdef CHAINING_STATS_EN
  logic [RP*32-1:0] stall_cnt;
`endif

  chaining_record_manager #(.RECORD_NUM(RN), .READ_PORTS(RP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef CHAINING_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Reference model: each slot is busy or not, remembers which elements were written.
  bit         mBusy [RN];
  bit         mDone [RN];
  bit         mVdV  [RN];
  int         mVd   [RN];
  int         mIdx  [RN];
  int         mVl   [RN];
  int         mCnt  [RN];
  bit [511:0] mWr   [RN];
  bit         mErrDup;
  bit [RP-1:0] eRespValid;
  bit [RP-1:0] eRespOk;
`ifdef CHAINING_STATS_EN
  longint     eStall [RP];
`endif
  int nVec = 0;
  int nMis = 0;
  int nextIdx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit mOlder(int r, int c);
    return bit'((r % 4) < (c % 4)) ^ bit'(r / 4) ^ bit'(c / 4);
  endfunction

  function automatic bit mHazard(int k, int vs, int off, int ridx);
    int e;
    if (!mBusy[k] || !mVdV[k] || ridx == mIdx[k] || mOlder(ridx, mIdx[k])) return 1'b0;
    e = ((vs * 64 + off) - mVd[k] * 64 + 2048) % 2048;
    return (e < mVl[k]) && !mWr[k][e];
  endfunction

  function automatic bit mAnyFree();
    for (int k = 0; k < RN; k++) if (!mBusy[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mIdxHeld(int x);
    for (int k = 0; k < RN; k++) if (mBusy[k] && mIdx[k] == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < RN; k++) begin
      mBusy[k] = 1'b0; mDone[k] = 1'b0; mWr[k] = '0; mCnt[k] = 0;
    end
    mErrDup    = 1'b0;
    eRespValid = '0;
    eRespOk    = '1;
`ifdef CHAINING_STATS_EN
    for (int p = 0; p < RP; p++) eStall[p] = 0;
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit preBusy [RN];
    bit preDone [RN];
    bit anyFree, dup, ok;
    int tgt, e;
`ifdef CHAINING_STATS_EN
    for (int p = 0; p < RP; p++)
      if (eRespValid[p] && !eRespOk[p] && eStall[p] < 64'hFFFF_FFFF) eStall[p]++;
`endif
    for (int p = 0; p < RP; p++) begin
      ok = 1'b1;
      if (bus.read_valid[p])
        for (int k = 0; k < RN; k++)
          if (mHazard(k, int'(bus.read_vs[p*5 +: 5]), int'(bus.read_offset[p*6 +: 6]),
                      int'(bus.read_instIndex[p*3 +: 3]))) ok = 1'b0;
      eRespValid[p] = bus.read_valid[p];
      eRespOk[p]    = ok;
    end
    anyFree = 1'b0; dup = 1'b0; tgt = -1;
    for (int k = 0; k < RN; k++) begin
      preBusy[k] = mBusy[k];
      preDone[k] = mDone[k];
      if (!mBusy[k]) begin
        anyFree = 1'b1;
        if (tgt < 0) tgt = k;
      end else if (mIdx[k] == int'(bus.alloc_instIndex)) begin
        dup = 1'b1;
      end
    end
    for (int k = 0; k < RN; k++) begin
      if (preBusy[k]) begin
        if (preDone[k] || (bus.retire_valid && mIdx[k] == int'(bus.retire_instIndex))) begin
          mBusy[k] = 1'b0; mDone[k] = 1'b0;
        end else if (bus.write_valid && mIdx[k] == int'(bus.write_instIndex)) begin
          e = ((int'(bus.write_vd) * 64 + int'(bus.write_offset)) - mVd[k] * 64 + 2048) % 2048;
          if (e < mVl[k] && !mWr[k][e]) begin
            mWr[k][e] = 1'b1;
            mCnt[k]++;
            if (mCnt[k] == mVl[k]) mDone[k] = 1'b1;
          end
        end
      end
    end
    if (bus.alloc_valid && anyFree) begin
      if (dup) begin
        mErrDup = 1'b1;
      end else begin
        mBusy[tgt] = 1'b1; mDone[tgt] = 1'b0; mVdV[tgt] = bus.alloc_vd_valid;
        mVd[tgt] = int'(bus.alloc_vd); mIdx[tgt] = int'(bus.alloc_instIndex);
        mVl[tgt] = int'(bus.alloc_vl); mWr[tgt] = '0; mCnt[tgt] = 0;
      end
    end
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0; bus.alloc_vd_valid = 1'b0; bus.alloc_vd = '0;
    bus.alloc_instIndex = '0; bus.alloc_vl = '0;
    bus.write_valid = 1'b0; bus.write_instIndex = '0; bus.write_vd = '0; bus.write_offset = '0;
    bus.retire_valid = 1'b0; bus.retire_instIndex = '0;
    bus.read_valid = '0; bus.read_vs = '0; bus.read_offset = '0; bus.read_instIndex = '0;
  endtask

  task automatic setAlloc(int vd, int idx, int vl);
    bus.alloc_valid = 1'b1; bus.alloc_vd_valid = 1'b1;
    bus.alloc_vd = 5'(vd); bus.alloc_instIndex = 3'(idx); bus.alloc_vl = 10'(vl);
  endtask

  task automatic setWrite(int vd, int off, int idx);
    bus.write_valid = 1'b1; bus.write_vd = 5'(vd);
    bus.write_offset = 6'(off); bus.write_instIndex = 3'(idx);
  endtask

  task automatic setRetire(int idx);
    bus.retire_valid = 1'b1; bus.retire_instIndex = 3'(idx);
  endtask

  task automatic setRead(int p, int vs, int off, int idx);
    bus.read_valid[p] = 1'b1;
    bus.read_vs[p*5 +: 5] = 5'(vs);
    bus.read_offset[p*6 +: 6] = 6'(off);
    bus.read_instIndex[p*3 +: 3] = 3'(idx);
  endtask

  // One clock: predict, let the edge pass, compare every output.
  task automatic cyc();
    modelStep();
    @(posedge clock);
    #1;
    chk("resp_valid", bus.resp_valid, eRespValid);
    chk("resp_ok", bus.resp_ok, eRespOk);
    chk("alloc_ready", bus.alloc_ready, mAnyFree());
    chk("err_dup", bus.err_dup, mErrDup);
`ifdef CHAINING_STATS_EN
    chk("stall_cnt0", stall_cnt[31:0], eStall[0]);
    chk("stall_cnt1", stall_cnt[63:32], eStall[1]);
`endif
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_alloc_ready", bus.alloc_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 2'b00);
    chk("rst_resp_ok", bus.resp_ok, 2'b11);
    chk("rst_err_dup", bus.err_dup, 1'b0);
`ifdef CHAINING_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 64'd0);
`endif
  endtask

  task automatic randomStim();
    int busy[$];
    int k, e, addr, vl;
    idle();
    for (int i = 0; i < RN; i++) if (mBusy[i]) busy.push_back(i);
    vl = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 512));
    if ($urandom_range(0, 3) == 0) begin
      if (busy.size() > 0 && $urandom_range(0, 7) == 0) begin
        setAlloc(int'($urandom_range(0, 31)), mIdx[busy[$urandom_range(0, busy.size() - 1)]], vl);
      end else if (!mIdxHeld((nextIdx + 4) % 8) && !mIdxHeld(nextIdx)) begin
        setAlloc(int'($urandom_range(0, 31)), nextIdx, vl);
        bus.alloc_vd_valid = ($urandom_range(0, 7) != 0);
        if (mAnyFree()) nextIdx = (nextIdx + 1) % 8;
      end
    end
    if (busy.size() > 0 && $urandom_range(0, 9) < 6) begin
      k = busy[$urandom_range(0, busy.size() - 1)];
      e = int'($urandom_range(0, (mVl[k] < 8) ? mVl[k] + 2 : 600));
      addr = (mVd[k] * 64 + e) % 2048;
      setWrite(addr / 64, addr % 64, mIdx[k]);
    end else if ($urandom_range(0, 3) == 0) begin
      setWrite(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
    end
    if (busy.size() > 0 && $urandom_range(0, 19) == 0)
      setRetire(mIdx[busy[$urandom_range(0, busy.size() - 1)]]);
    for (int p = 0; p < RP; p++) begin
      if ($urandom_range(0, 9) < 7) begin
        k = int'($urandom_range(0, RN - 1));
        setRead(p, (mVd[k] + int'($urandom_range(0, 17))) % 32,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < RN; k++) begin
      mVd[k] = 0; mIdx[k] = 0; mVl[k] = 1; mVdV[k] = 1'b0;
    end
    doReset();

    // Unwritten element of an older writer stalls a younger reader.
    idle(); setAlloc(8, 1, 64); cyc();
    idle(); setRead(0, 8, 5, 2); setRead(1, 9, 0, 2); cyc();
    chk("tp1_resp_valid", bus.resp_valid[0], 1'b1);
    chk("tp1_stall", bus.resp_ok[0], 1'b0);
    chk("tp1_beyond_vl_ok", bus.resp_ok[1], 1'b1);
    idle(); setWrite(8, 5, 1); cyc();
    idle(); setRead(0, 8, 5, 2); cyc();
    chk("tp2_written_ok", bus.resp_ok[0], 1'b1);
    idle(); setRead(0, 8, 6, 2); cyc();
    chk("tp2_unwritten_stall", bus.resp_ok[0], 1'b0);

    // Completion frees the slot so four more allocations fit.
    doReset();
    idle(); setAlloc(8, 1, 2); cyc();
    idle(); setWrite(8, 0, 1); cyc();
    idle(); setWrite(8, 1, 1); cyc();
    chk("tp3_ready_complete", bus.alloc_ready, 1'b1);
    idle(); cyc();
    for (int i = 2; i <= 4; i++) begin
      idle(); setAlloc(20, i, 64); cyc();
    end
    chk("tp3_slot_reused", bus.alloc_ready, 1'b1);
    idle(); setAlloc(20, 5, 64); cyc();
    chk("tp3_full", bus.alloc_ready, 1'b0);

    // Full table, retire, duplicate allocation.
    doReset();
    for (int i = 0; i < 4; i++) begin
      idle(); setAlloc(i * 4, i, 64); cyc();
    end
    chk("tp4_full", bus.alloc_ready, 1'b0);
    idle(); setRetire(0); cyc();
    chk("tp4_retire_frees", bus.alloc_ready, 1'b1);
    idle(); setAlloc(12, 2, 64); cyc();
    chk("tp4_err_dup", bus.err_dup, 1'b1);
    chk("tp4_dup_no_install", bus.alloc_ready, 1'b1);

    // Wrap bit handling.
    doReset();
    idle(); setAlloc(4, 3, 64); cyc();
    idle(); setRead(0, 4, 0, 4); cyc();
    chk("tp5_younger_stall", bus.resp_ok[0], 1'b0);
    doReset();
    idle(); setAlloc(4, 4, 64); cyc();
    idle(); setRead(0, 4, 0, 3); cyc();
    chk("tp5_older_ok", bus.resp_ok[0], 1'b1);

    // Queries see pre-update state when a write lands in the same cycle.
    doReset();
    idle(); setAlloc(8, 1, 64); cyc();
    idle(); setRead(0, 8, 5, 2); setRead(1, 8, 5, 3); setWrite(8, 5, 1); cyc();
    chk("tp6_pre_update", bus.resp_ok, 2'b00);
    idle(); setRead(0, 8, 5, 2); setRead(1, 8, 5, 3); cyc();
    chk("tp6_after_write", bus.resp_ok, 2'b11);
`ifdef CHAINING_STATS_EN
    chk("tp6_stall_cnt", stall_cnt, {32'd1, 32'd1});
`endif

    // Edge of the 8-register mask: last element stalls, first past it does not.
    doReset();
    idle(); setAlloc(8, 1, 512); cyc();
    idle(); setRead(0, 15, 63, 2); setRead(1, 16, 0, 2); cyc();
    chk("mask_edge", bus.resp_ok, 2'b10);

    doReset();
    nextIdx = 0;
    repeat (3000) begin
      randomStim();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
